// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the memory arbiter: FSM state
//               encoding and the owner (grant) encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Owner / grant encoding
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IF   = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester (fetch / data) arbiter in front of a single
//               shared memory port. One access in flight at a time; the
//               winner's command is registered onto mem_* and held until
//               mem_ack, then the owner's ready pulses for one cycle.
//               Build option: MEM_ARB_RR_EN selects round-robin arbitration
//               on simultaneous requests; otherwise data has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  // shared memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  // grant status
  output logic [1:0]        owner
);

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_owner;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                w_any_req;
  logic                w_grant_d;

  assign w_any_req = if_req | d_req;

`ifdef MEM_ARB_RR_EN
  // 1 when the most recent grant went to data; reset leaves it pointing at
  // fetch so that data wins the first contested grant.
  logic r_last_d;

  // Contested grants go to whichever requester was not served last
  assign w_grant_d = d_req & (~if_req | ~r_last_d);

  // Pointer follows every grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_d <= 1'b0;
    end else if (r_state == ST_IDLE && w_any_req) begin
      r_last_d <= w_grant_d;
    end
  end
`else
  // Fixed priority: data always beats fetch
  assign w_grant_d = d_req;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_any_req) w_next = ST_BUSY;
      ST_BUSY: if (mem_ack)   w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Command latch on grant, read-data capture on ack, owner release after RESP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner     <= OWN_NONE;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_owner     <= w_grant_d ? OWN_D   : OWN_IF;
            r_mem_we    <= w_grant_d ? d_we    : 1'b0;
            r_mem_addr  <= w_grant_d ? d_addr  : if_addr;
            r_mem_wdata <= w_grant_d ? d_wdata : '0;
          end
        end
        ST_BUSY: begin
          // Stores leave d_rdata untouched
          if (mem_ack) begin
            if (r_owner == OWN_IF)  r_if_rdata <= mem_rdata;
            else if (!r_mem_we)     r_d_rdata  <= mem_rdata;
          end
        end
        ST_RESP: r_owner <= OWN_NONE;
        default: r_owner <= OWN_NONE;
      endcase
    end
  end

  assign mem_req   = (r_state == ST_BUSY);
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign owner     = r_owner;
  assign if_ready  = (r_state == ST_RESP) && (r_owner == OWN_IF);
  assign d_ready   = (r_state == ST_RESP) && (r_owner == OWN_D);

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ready, d_ready, mem_req, mem_we;
  logic [1:0]  owner;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .owner(owner)
  );

  // advance one clock, settle 1 time unit past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // outputs expected idle: no request, no ready, no owner
  task automatic check_quiet(input string tag);
    check({tag, ".mem_req"}, 32'(mem_req), 32'd0);
    check({tag, ".if_ready"}, 32'(if_ready), 32'd0);
    check({tag, ".d_ready"}, 32'(d_ready), 32'd0);
    check({tag, ".owner"}, 32'(owner), 32'd0);
  endtask

  logic [1:0]  exp_own [4];
  logic [31:0] data_v;

  initial begin
    reset = 1'b1; if_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    #1;
    // ---- reset state
    check_quiet("rst");
    check("rst.mem_we", 32'(mem_we), 32'd0);
    check("rst.mem_addr", mem_addr, 32'd0);
    check("rst.mem_wdata", mem_wdata, 32'd0);
    check("rst.if_rdata", if_rdata, 32'd0);
    check("rst.d_rdata", d_rdata, 32'd0);
    step(); step();
    reset = 1'b0;
    step();

    // ---- single fetch, ack 3 cycles after mem_req, address change mid-access
    if_req = 1; if_addr = 32'h100;
    step();
    check("f1.mem_req", 32'(mem_req), 32'd1);
    check("f1.mem_addr", mem_addr, 32'h100);
    check("f1.mem_we", 32'(mem_we), 32'd0);
    check("f1.owner", 32'(owner), 32'd1);
    if_addr = 32'h104;
    step();
    check("f1.addr_hold1", mem_addr, 32'h100);
    check("f1.req_hold", 32'(mem_req), 32'd1);
    step();
    check("f1.addr_hold2", mem_addr, 32'h100);
    check("f1.no_ready_busy", 32'(if_ready), 32'd0);
    step();
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_ack = 0;
    check("f1.if_ready", 32'(if_ready), 32'd1);
    check("f1.if_rdata", if_rdata, 32'hDEADBEEF);
    check("f1.d_ready", 32'(d_ready), 32'd0);
    check("f1.mem_req_resp", 32'(mem_req), 32'd0);
    check("f1.addr_resp", mem_addr, 32'h100);
    if_req = 0;
    step();
    check_quiet("f1.idle");

    // ---- simultaneous fetch + store: data first
    if_req = 1; if_addr = 32'h300;
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h55;
    step();
    check("s.owner_d", 32'(owner), 32'd2);
    check("s.mem_we", 32'(mem_we), 32'd1);
    check("s.mem_addr", mem_addr, 32'h200);
    check("s.mem_wdata", mem_wdata, 32'h55);
    mem_ack = 1; mem_rdata = 32'h12345678;
    step();
    mem_ack = 0;
    check("s.d_ready", 32'(d_ready), 32'd1);
    check("s.if_ready_lo", 32'(if_ready), 32'd0);
    check("s.d_rdata_store", d_rdata, 32'd0);
    d_req = 0; d_we = 0;
    step();
    check_quiet("s.idle");
    step();
    check("s.owner_if", 32'(owner), 32'd1);
    check("s.if_addr", mem_addr, 32'h300);
    check("s.if_we", 32'(mem_we), 32'd0);
    mem_ack = 1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_ack = 0;
    check("s.if_ready", 32'(if_ready), 32'd1);
    check("s.d_ready_lo", 32'(d_ready), 32'd0);
    check("s.if_rdata", if_rdata, 32'hCAFEF00D);
    if_req = 0;
    step();
    check_quiet("s.idle2");

    // ---- stray ack in IDLE
    mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    step();
    mem_ack = 0;
    check_quiet("ack_idle");
    check("ack_idle.if_rdata", if_rdata, 32'hCAFEF00D);
    check("ack_idle.d_rdata", d_rdata, 32'd0);
    step();
    check_quiet("ack_idle2");

    // ---- both held for 4 loads
`ifdef MEM_ARB_RR_EN
    exp_own = '{2'd2, 2'd1, 2'd2, 2'd1};
`else
    exp_own = '{2'd2, 2'd2, 2'd2, 2'd2};
`endif
    if_req = 1; if_addr = 32'h500; d_req = 1; d_we = 0; d_addr = 32'h600;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("hold%0d.owner", k), 32'(owner), 32'(exp_own[k]));
      data_v = 32'hA000_0000 + 32'(k);
      mem_ack = 1; mem_rdata = data_v;
      step();
      mem_ack = 0;
      if (exp_own[k] == 2'd2) begin
        check($sformatf("hold%0d.d_ready", k), 32'(d_ready), 32'd1);
        check($sformatf("hold%0d.d_rdata", k), d_rdata, data_v);
        check($sformatf("hold%0d.if_ready", k), 32'(if_ready), 32'd0);
      end else begin
        check($sformatf("hold%0d.if_ready", k), 32'(if_ready), 32'd1);
        check($sformatf("hold%0d.if_rdata", k), if_rdata, data_v);
        check($sformatf("hold%0d.d_ready", k), 32'(d_ready), 32'd0);
      end
      step();
    end
    if_req = 0; d_req = 0;
    step();
    check_quiet("hold.idle");

    // ---- reset mid-access, then late ack
    if_req = 1; if_addr = 32'h400;
    step();
    check("r.mem_req", 32'(mem_req), 32'd1);
    reset = 1;
    #1;
    check_quiet("r.async");
    check("r.mem_addr", mem_addr, 32'd0);
    check("r.if_rdata", if_rdata, 32'd0);
    if_req = 0;
    step();
    reset = 0;
    mem_ack = 1; mem_rdata = 32'h87654321;
    step();
    mem_ack = 0;
    check_quiet("r.late_ack");
    step();
    check_quiet("r.after");
    check("r.if_rdata_after", if_rdata, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire
